data_mem_responder: RTL

- Responder end of the CPU data-memory interface: accepts load/store requests from the MEM stage (enable, write, byte selects, size, address, write data) and returns read data.
- Owns a word-organised data RAM with byte-lane writes.
- Inserts a programmable number of wait states and drives a stall back to the pipeline hazard logic.
- Checks alignment and aborts requests on pipeline flush; sits between the mips core and the SoC data-memory slot.

---
 rtl/data_mem_responder_pkg.sv | 25 ++
 rtl/data_mem_responder_ram.sv | 39 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state encoding and the alignment rule.
package mem_defs;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The reserved size encoding is always treated as an alignment error.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addrLo[0];
            SIZE_WORD: return (addrLo != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word-organised RAM with four byte-wide write lanes and a registered read port
// whose output holds until the next read.
module byte_lane_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    // Only the read-data register is reset; the array contents survive reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: wait-state insertion, stall
// generation, alignment checking and flush abort in front of a byte-lane RAM.
module data_mem_responder
    import mem_defs::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int WAIT_W      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_en,
    input  logic        i_mem_we,
    input  logic [3:0]  i_mem_sel,
    input  logic [1:0]  i_mem_size,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic        i_mem_flush,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_stall,
    output logic        o_mem_done,
    output logic        o_addr_err,
    output logic        o_err_store
);

    localparam logic [WAIT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic              NO_WAIT  = (WAIT_CYCLES == 0);

    state_t            r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_done;
    logic              r_addrErr;
    logic              r_errStore;

    logic       w_misaligned;
    logic       w_req;
    logic       w_idle;
    logic       w_idleErr;
    logic       w_access;
    logic [3:0] w_ramWe;
    logic       w_ramRe;
    logic       w_unusedAddr;

    assign w_misaligned = isMisaligned(i_mem_size, i_mem_addr[1:0]);
    assign w_req        = i_mem_en & ~i_mem_flush;
    assign w_idle       = (r_state == ST_IDLE);
    assign w_idleErr    = w_idle & w_req & w_misaligned;

    // The access fires on the edge that moves the FSM into DONE.
    assign w_access = (w_idle & w_req & ~w_misaligned & NO_WAIT)
                    | ((r_state == ST_WAIT) & ~i_mem_flush & (r_cnt == '0));

    assign w_ramWe = (w_access & i_mem_we) ? i_mem_sel : 4'b0000;
    assign w_ramRe = w_access & ~i_mem_we;

    assign w_unusedAddr = &{1'b0, i_mem_addr[31:ADDR_WIDTH+2]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_addrErr  <= 1'b0;
            r_errStore <= 1'b0;
        end else begin
            r_done     <= w_access;
            r_addrErr  <= w_idleErr;
            r_errStore <= w_idleErr & i_mem_we;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_misaligned) begin
                        if (NO_WAIT) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_mem_flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    byte_lane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_ramWe),
        .i_re   (w_ramRe),
        .i_addr (i_mem_addr[ADDR_WIDTH+1:2]),
        .i_wdata(i_mem_wdata),
        .o_rdata(o_mem_rdata)
    );

    // Misaligned requests never stall so the core can take the exception.
    assign o_mem_stall = i_mem_en & ~i_mem_flush & (r_state != ST_DONE) & ~(w_idle & w_misaligned);
    assign o_mem_done  = r_done;
    assign o_addr_err  = r_addrErr;
    assign o_err_store = r_errStore;

endmodule
